// File: rtl/aes128_key_expander_pkg.sv
// Shared AES-128 types, constants and byte/word helpers used by the key schedule and round logic.
package aes128_key_expander_pkg;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned KEY_W         = 128;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned CTR_W         = 4;
  localparam logic [7:0]  RCON_INIT     = 8'h01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } ks_state_e;

  // Round key viewed as its four 32-bit words, w0 in the MSBs.
  typedef struct packed {
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } key_words_t;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes128_key_expander_if.sv
// Key-schedule port bundle: start/key load, round-key read port and shared S-box link.
interface aes128_key_expander_if;
  import aes128_key_expander_pkg::*;

  logic              init;
  logic [KEY_W-1:0]  key;
  logic [CTR_W-1:0]  round;
  logic [KEY_W-1:0]  round_key;
  logic [WORD_W-1:0] sboxw;
  logic [WORD_W-1:0] new_sboxw;
  logic              sbox_req;
  logic              ready;

  modport master (
    output init, key, round, new_sboxw,
    input  round_key, sboxw, sbox_req, ready
  );

  modport slave (
    input  init, key, round, new_sboxw,
    output round_key, sboxw, sbox_req, ready
  );

endinterface

// File: rtl/aes128_key_expander.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry flop register file.
module aes128_key_expander
  import aes128_key_expander_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic                    clk,
  input  logic                    reset,
  aes128_key_expander_if.slave    bus
);

  localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;

  generate
    if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
      $error("aes128_key_expander: NUM_ROUNDS must be 10");
    end
  endgenerate

  ks_state_e         state;
  ks_state_e         state_nxt;
  logic [CTR_W-1:0]  round_ctr;
  logic [7:0]        rcon_reg;
  key_words_t        prev_key_reg;
  logic [KEY_W-1:0]  key_mem [NUM_KEYS];
  logic              ready_reg;

  logic              accept_c;
  logic              gen_c;
  logic              last_c;
  logic [WORD_W-1:0] t_c;
  key_words_t        next_key_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath strobes; init is only honoured from IDLE
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    gen_c     = 1'b0;
    last_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.init) begin
          accept_c  = 1'b1;
          state_nxt = ST_GEN;
        end
      end
      ST_GEN: begin
        gen_c = 1'b1;
        if (round_ctr == CTR_W'(NUM_ROUNDS)) begin
          last_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Rotate after SubWord (equivalent to the textbook order), then the word chain
  always_comb begin
    t_c           = rot_word(bus.new_sboxw) ^ {rcon_reg, 24'h0};
    next_key_c    = '0;
    next_key_c.w0 = prev_key_reg.w0 ^ t_c;
    next_key_c.w1 = prev_key_reg.w1 ^ next_key_c.w0;
    next_key_c.w2 = prev_key_reg.w2 ^ next_key_c.w1;
    next_key_c.w3 = prev_key_reg.w3 ^ next_key_c.w2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_ctr    <= '0;
      rcon_reg     <= 8'h00;
      prev_key_reg <= '0;
      ready_reg    <= 1'b1;
      for (int unsigned i = 0; i < NUM_KEYS; i++) key_mem[i] <= '0;
    end else begin
      if (accept_c) begin
        key_mem[0]   <= bus.key;
        prev_key_reg <= bus.key;
        rcon_reg     <= RCON_INIT;
        round_ctr    <= CTR_W'(1);
        ready_reg    <= 1'b0;
      end
      if (gen_c) begin
        for (int unsigned i = 1; i < NUM_KEYS; i++) begin
          if (round_ctr == CTR_W'(i)) key_mem[i] <= next_key_c;
        end
        prev_key_reg <= next_key_c;
        rcon_reg     <= gm2(rcon_reg);
        round_ctr    <= last_c ? '0 : round_ctr + CTR_W'(1);
        if (last_c) ready_reg <= 1'b1;
      end
    end
  end

  assign bus.ready    = ready_reg;
  assign bus.sbox_req = (state == ST_GEN);
  assign bus.sboxw    = (state == ST_GEN) ? prev_key_reg.w3 : '0;

  // Read port; indices past the last round return zero
  always_comb begin
    bus.round_key = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (bus.round == CTR_W'(i)) bus.round_key = key_mem[i];
    end
  end

endmodule

// File: tb/tb_aes128_key_expander.sv
// Self-checking bench for aes128_key_expander with a reference FIPS-197 key expansion and S-box.
module tb_aes128_key_expander;

  localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0b7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b27509832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cfd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2cd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdbe0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08ba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9ee1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16;
  localparam logic [0:9][7:0] RCON_T = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] exp;
  } vec_t;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  sb_t  sb_q[$];
  vec_t vecs[5];

  aes128_key_expander_if bus();

  aes128_key_expander #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Shared S-box, muxed to this user only while it holds the request
  always_comb bus.new_sboxw = sub_word(bus.sbox_req ? bus.sboxw : 32'h0);

  function automatic logic [10:0][127:0] expand(input logic [127:0] k);
    logic [31:0]        w [44];
    logic [31:0]        tmp;
    logic [10:0][127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {RCON_T[i/4-1], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_zeros(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) sb_q.push_back('{round: 4'(r), exp: 128'h0});
  endtask

  task automatic drain;
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.round = e.round;
      #1;
      check($sformatf("round_key[%0d]", e.round), bus.round_key, e.exp);
    end
  endtask

  // One expansion run; optional stray init at inj_cycle, optional reset at rst_cycle
  task automatic run_gen(input logic [127:0] key, input int inj_cycle,
                         input logic [127:0] inj_key, input int rst_cycle);
    logic [10:0][127:0] rk;
    int n;
    int req_hi;
    rk = expand(key);
    bus.key  = key;
    bus.init = 1'b1;
    tick();
    bus.init = 1'b0;
    bus.key  = ~key;
    n = 0;
    req_hi = 0;
    while (bus.ready == 1'b0 && n < 20) begin
      if (n == rst_cycle) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        return;
      end
      if (bus.sbox_req) req_hi++;
      if (n < 10) begin
        check($sformatf("rcon[%0d]", n), 128'(dut.rcon_reg), 128'(RCON_T[n]));
        check($sformatf("sboxw[%0d]", n), 128'(bus.sboxw), 128'(rk[n][31:0]));
      end
      if (n == inj_cycle) begin
        bus.key  = inj_key;
        bus.init = 1'b1;
      end
      tick();
      bus.init = 1'b0;
      n++;
    end
    check("ready_low_cycles", 128'(n), 128'(10));
    check("sbox_req_cycles", 128'(req_hi), 128'(10));
    check("idle_sbox_req", 128'(bus.sbox_req), 128'(0));
    check("idle_sboxw", 128'(bus.sboxw), 128'(0));
    for (int r = 0; r < 11; r++) sb_q.push_back('{round: 4'(r), exp: rk[r]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.init  = 1'b0;
    bus.key   = '0;
    bus.round = '0;

    vecs[0] = '{key: KEY_A1, round: 4'd1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{key: KEY_A1, round: 4'd10, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{key: KEY_A1, round: 4'd0,  exp: KEY_A1};
    vecs[3] = '{key: 128'h0, round: 4'd1,  exp: 128'h62636363626363636263636362636363};
    vecs[4] = '{key: 128'h0, round: 4'd10, exp: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    // Reset state
    tick();
    tick();
    check("reset_ready", 128'(bus.ready), 128'(1));
    check("reset_sbox_req", 128'(bus.sbox_req), 128'(0));
    check("reset_sboxw", 128'(bus.sboxw), 128'(0));
    push_zeros(0, 15);
    drain();
    reset = 1'b0;
    tick();

    // Known-answer vectors
    for (int v = 0; v < 5; v++) begin
      run_gen(vecs[v].key, -1, '0, -1);
      sb_q.push_back('{round: vecs[v].round, exp: vecs[v].exp});
      drain();
    end

    // init with another key mid-run must be ignored
    run_gen(KEY_A1, 5, KEY_C1, -1);
    drain();

    // init on the edge ready rises is swallowed by the finishing run
    run_gen(128'h0, 9, KEY_A1, -1);
    check("edge_init_ready", 128'(bus.ready), 128'(1));
    tick();
    check("edge_init_still_ready", 128'(bus.ready), 128'(1));
    check("edge_init_sbox_req", 128'(bus.sbox_req), 128'(0));
    drain();

    // Reset at cycle 4 of a run, then a clean A.1 run
    run_gen(KEY_C1, -1, '0, 4);
    check("midrst_ready", 128'(bus.ready), 128'(1));
    check("midrst_sbox_req", 128'(bus.sbox_req), 128'(0));
    check("midrst_sboxw", 128'(bus.sboxw), 128'(0));
    push_zeros(0, 15);
    drain();
    run_gen(KEY_A1, -1, '0, -1);
    drain();

    // Out-of-range reads with populated storage
    push_zeros(11, 15);
    drain();

    // Back-to-back runs: second key overwrites every entry
    run_gen(KEY_A1, -1, '0, -1);
    sb_q.delete();
    run_gen(KEY_C1, -1, '0, -1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
